bitwise_serial_unit: RTL and testbench

//  Parametrised, multi-cycle bitwise logic unit: the next generation of the fixed 32-bit gate arrays.

---
 rtl/bsu_pkg.sv | 17 +
 rtl/bitwise_lane.sv | 25 ++
 rtl/bitwise_serial_unit.sv | 157 +++++++++++++++
 tb/tb_bitwise_serial_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsu_pkg.sv
// Shared opcodes and FSM state encodings for the bitwise serial unit.
package bsu_pkg;

  localparam int unsigned OP_W = 2;

  localparam logic [OP_W-1:0] OP_AND  = 2'b00;
  localparam logic [OP_W-1:0] OP_OR   = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
  localparam logic [OP_W-1:0] OP_ACCX = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage : bsu_pkg

// File: rtl/bitwise_lane.sv
// Combinational LANE-wide logic slice, reused every RUN cycle.
module bitwise_lane
  import bsu_pkg::*;
#(
  parameter int unsigned LANE = 8
) (
  input  logic [LANE-1:0] a,
  input  logic [LANE-1:0] b,
  input  logic [LANE-1:0] acc,
  input  logic [OP_W-1:0] op,
  output logic [LANE-1:0] y
);

  // Select the slice operation; ACCX folds the accumulator copy into a^b.
  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_ACCX: y = acc ^ a ^ b;
    endcase
  end

endmodule : bitwise_lane

// File: rtl/bitwise_serial_unit.sv
// Multi-cycle bitwise logic unit: AND/OR/XOR/XOR-accumulate, LANE bits per cycle.
module bitwise_serial_unit
  import bsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANE  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             parity,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / LANE;
  localparam int unsigned CW = $clog2(N) + 1;

  // Reject lane configurations that do not tile the operand width.
  if (LANE < 1 || LANE > WIDTH || (WIDTH % LANE) != 0) begin : g_bad_lane
    $error("bitwise_serial_unit: LANE must divide WIDTH and lie in 1..WIDTH");
  end

  state_e           state_q,  state_d;
  logic [OP_W-1:0]  op_q,     op_d;
  logic [WIDTH-1:0] a_sh_q,   a_sh_d;
  logic [WIDTH-1:0] b_sh_q,   b_sh_d;
  logic [WIDTH-1:0] acc_sh_q, acc_sh_d;
  logic [WIDTH-1:0] work_q,   work_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             parity_q, parity_d;
  logic             zero_q,   zero_d;

  logic [LANE-1:0]  lane_y;
  logic [WIDTH-1:0] work_shift;

  bitwise_lane #(.LANE(LANE)) u_lane (
    .a   (a_sh_q[LANE-1:0]),
    .b   (b_sh_q[LANE-1:0]),
    .acc (acc_sh_q[LANE-1:0]),
    .op  (op_q),
    .y   (lane_y)
  );

  // Next-state, datapath and output computation.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_sh_d = acc_sh_q;
    work_d   = work_q;
    acc_d    = acc_q;
    count_d  = count_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    result_d = result_q;
    parity_d = parity_q;
    zero_d   = zero_q;

    // Lane result enters at the MSB so the first lane ends up lowest after N shifts.
    work_shift = (work_q >> LANE) | (WIDTH'(lane_y) << (WIDTH - LANE));

    if (acc_clr && (state_q != ST_RUN)) begin
      acc_d = '0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d  = ST_RUN;
          busy_d   = 1'b1;
          op_d     = op;
          a_sh_d   = a;
          b_sh_d   = b;
          count_d  = '0;
          acc_sh_d = '0;
          if (op == OP_ACCX) begin
            acc_sh_d = acc_clr ? '0 : acc_q;
          end
        end
      end
      ST_RUN: begin
        busy_d   = 1'b1;
        a_sh_d   = a_sh_q >> LANE;
        b_sh_d   = b_sh_q >> LANE;
        acc_sh_d = acc_sh_q >> LANE;
        work_d   = work_shift;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d  = ST_DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          count_d  = '0;
          result_d = work_shift;
          parity_d = ^work_shift;
          zero_d   = (work_shift == '0);
          if (op_q == OP_ACCX) begin
            acc_d = work_shift;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_AND;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_sh_q <= '0;
      work_q   <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      parity_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_sh_q <= acc_sh_d;
      work_q   <= work_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      parity_q <= parity_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign parity = parity_q;
  assign zero   = zero_q;

endmodule : bitwise_serial_unit

// File: tb/tb_bitwise_serial_unit.sv
// Scoreboard bench for bitwise_serial_unit at LANE = 8, 1 and 32.
module tb_bitwise_serial_unit;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [2:0]  start_v;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        acc_clr;

  logic        busy0, done0, par0, zero0;
  logic        busy1, done1, par1, zero1;
  logic        busy2, done2, par2, zero2;
  logic [31:0] res0, res1, res2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int unsigned cyc;
  int n_cmp;
  int n_err;

  bitwise_serial_unit #(.WIDTH(32), .LANE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .op(op), .a(a), .b(b),
    .acc_clr(acc_clr), .busy(busy0), .done(done0), .result(res0),
    .parity(par0), .zero(zero0)
  );

  bitwise_serial_unit #(.WIDTH(32), .LANE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .op(op), .a(a), .b(b),
    .acc_clr(acc_clr), .busy(busy1), .done(done1), .result(res1),
    .parity(par1), .zero(zero1)
  );

  bitwise_serial_unit #(.WIDTH(32), .LANE(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .op(op), .a(a), .b(b),
    .acc_clr(acc_clr), .busy(busy2), .done(done2), .result(res2),
    .parity(par2), .zero(zero2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int unsigned nlat(input int id);
    case (id)
      0: return 4;
      1: return 32;
      default: return 1;
    endcase
  endfunction

  function automatic int qsize(input int id);
    case (id)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Expected parity/zero follow directly from the hand-computed result.
  task automatic push(input int id, input logic [31:0] res, input int unsigned done_cyc);
    exp_t e;
    e.res = res;
    e.cyc = done_cyc;
    case (id)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int id, input logic d, input logic [31:0] r,
                     input logic p, input logic z);
    exp_t e;
    if (d) begin
      if (qsize(id) == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dut%0d unexpected done: got done=1 result %h, required no done (cycle %0d)",
                 id, r, cyc);
      end else begin
        case (id)
          0: e = q0.pop_front();
          1: e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk($sformatf("dut%0d result", id), r, e.res);
        chk($sformatf("dut%0d parity", id), 32'(p), 32'(^e.res));
        chk($sformatf("dut%0d zero", id), 32'(z), 32'(e.res == 32'h0));
        chk($sformatf("dut%0d done cycle", id), 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  // Monitor: pops an expectation every time any DUT pulses done.
  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, done0, res0, par0, zero0);
      mon(1, done1, res1, par1, zero1);
      mon(2, done2, res2, par2, zero2);
    end
  end

  task automatic wait_q(input int id);
    int n;
    n = 0;
    while (qsize(id) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (qsize(id) != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL dut%0d timeout: %0d done pulses pending, required 0", id, qsize(id));
      case (id)
        0: q0.delete();
        1: q1.delete();
        default: q2.delete();
      endcase
    end
  endtask

  task automatic issue(input int id, input logic [1:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic clr, input logic [31:0] er);
    @(negedge clk);
    op = o;
    a = aa;
    b = bb;
    acc_clr = clr;
    start_v[id] = 1'b1;
    push(id, er, cyc + 1 + nlat(id));
    @(negedge clk);
    start_v = '0;
    acc_clr = 1'b0;
    wait_q(id);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"},   32'(busy0),  32'd0);
    chk({tag, " done"},   32'(done0),  32'd0);
    chk({tag, " result"}, res0,        32'h0);
    chk({tag, " zero"},   32'(zero0),  32'd1);
    chk({tag, " parity"}, 32'(par0),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  initial begin
    int unsigned c;
    cyc = 0;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start_v = 3'b001;
    op = 2'b10;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    acc_clr = 1'b0;

    // T1: reset held with start asserted
    repeat (3) @(negedge clk);
    chk_reset_vals("T1 reset");
    rst_n = 1'b1;
    start_v = '0;
    repeat (8) @(negedge clk);

    // T2: XOR, 5-cycle latency
    issue(0, 2'b10, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'hFF00_12CB);

    // T3: complement pair under AND gives zero, then AND and OR
    issue(0, 2'b00, 32'hA5A5_5A5A, 32'h5A5A_A5A5, 1'b0, 32'h0000_0000);
    issue(0, 2'b00, 32'hFFFF_0000, 32'h00FF_FF00, 1'b0, 32'h00FF_0000);
    issue(0, 2'b01, 32'hFFFF_0000, 32'h00FF_FF00, 1'b0, 32'hFFFF_FF00);

    // T5a: start and operand changes mid-RUN are ignored
    @(negedge clk);
    op = 2'b10;
    a = 32'hF0F0_1234;
    b = 32'h0FF0_00FF;
    start_v[0] = 1'b1;
    push(0, 32'hFF00_12CB, cyc + 1 + nlat(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      op = 2'b00;
      a = 32'h0000_0000;
      b = 32'hFFFF_FFFF;
      start_v[0] = 1'b1;
      chk("T5 busy mid-run", 32'(busy0), 32'd1);
      chk("T5 result held mid-run", res0, 32'hFFFF_FF00);
    end
    @(negedge clk);
    start_v = '0;
    wait_q(0);

    // T5b: start held through DONE gives back-to-back ops every 5 cycles
    @(negedge clk);
    c = cyc;
    op = 2'b01;
    a = 32'h1234_5678;
    b = 32'h8765_4321;
    start_v[0] = 1'b1;
    push(0, 32'h9775_5779, c + 5);
    push(0, 32'h9775_5779, c + 10);
    repeat (6) @(negedge clk);
    start_v = '0;
    wait_q(0);

    // T4: accumulator chain
    issue(0, 2'b11, 32'h0000_0007, 32'h0000_0000, 1'b0, 32'h0000_0007);
    @(negedge clk);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    issue(0, 2'b11, 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003);
    issue(0, 2'b11, 32'h0000_0004, 32'h0000_0008, 1'b0, 32'h0000_000F);
    issue(0, 2'b11, 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000);
    issue(0, 2'b01, 32'hFFFF_0000, 32'h00FF_FF00, 1'b0, 32'hFFFF_FF00);

    // T6a: reset during RUN cycle 2 aborts without a done pulse
    @(negedge clk);
    op = 2'b10;
    a = 32'hF0F0_1234;
    b = 32'h0FF0_00FF;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("T6 abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // T6b: same XOR at LANE=1, LANE=32 and LANE=8
    @(negedge clk);
    op = 2'b10;
    a = 32'hF0F0_1234;
    b = 32'h0FF0_00FF;
    start_v = 3'b110;
    push(1, 32'hFF00_12CB, cyc + 1 + nlat(1));
    push(2, 32'hFF00_12CB, cyc + 1 + nlat(2));
    @(negedge clk);
    start_v = '0;
    wait_q(2);
    wait_q(1);
    issue(0, 2'b10, 32'hF0F0_1234, 32'h0FF0_00FF, 1'b0, 32'hFF00_12CB);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_bitwise_serial_unit
